// File: rtl/hls_ctrl_pkg.sv
// Shared definitions for the ap_ctrl_hs responder: state encoding and
// default latency / counter-width constants.
package hls_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ctrl_state_t;

  localparam int DEF_READY_LAT = 2;
  localparam int DEF_DONE_LAT  = 8;
  localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/hls_sat_counter.sv
// Saturating up-counter: counts enabled edges and sticks at all-ones
// instead of wrapping back to zero.
module hls_sat_counter
  import hls_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = '1;
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  // Count one per enabled edge, holding once the maximum is reached.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_en && (r_count != MAX_CNT)) begin
      r_count <= r_count + ONE_CNT;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hls_ctrl_responder.sv
// Core-side responder for the HLS ap_ctrl_hs block-level handshake.
// Accepts ap_start, pulses ap_ready and ap_done after fixed latencies,
// counts completed transactions and busy cycles, and flags an initiator
// that drops ap_start before it has seen ap_ready.
module hls_ctrl_responder
  import hls_ctrl_pkg::*;
#(
  parameter int READY_LAT = DEF_READY_LAT,
  parameter int DONE_LAT  = DEF_DONE_LAT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ap_start,
  output logic             o_ap_idle,
  output logic             o_ap_ready,
  output logic             o_ap_done,
  output logic [CNT_W-1:0] o_doneCount,
  output logic [CNT_W-1:0] o_busyCycles,
  output logic             o_protocolErr
);

  // Latency targets in counter width; all comparisons are unsigned.
  localparam logic [CNT_W-1:0] READY_CNT = CNT_W'(READY_LAT);
  localparam logic [CNT_W-1:0] DONE_CNT  = CNT_W'(DONE_LAT);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  ctrl_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_idle;
  logic             r_ready;
  logic             r_done;
  logic             r_protoErr;

  ctrl_state_t      w_stateNext;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_idleNext;
  logic             w_startViol;
  logic             w_readySet;
  logic             w_doneSet;
  logic             w_busyNow;

  // State register plus the registered handshake outputs and sticky error.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idle     <= 1'b1;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_protoErr <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_idle  <= w_idleNext;
      r_ready <= w_readySet;
      r_done  <= w_doneSet;
      if (w_startViol) begin
        r_protoErr <= 1'b1;
      end
    end
  end

  // Next-state logic: r_cnt holds k just before edge t0+k, so the value it
  // takes at an edge tells which latency target that edge reaches. ap_start
  // must stay high until ap_ready is visible; once the ready pulse is on the
  // wire the initiator may drop it, so only edges with r_cnt < READY_LAT are
  // checked.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_idleNext  = r_idle;
    w_startViol = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_ap_start) begin
          w_stateNext = BUSY;
          w_cntNext   = ONE_CNT;
          w_idleNext  = 1'b0;
        end
      end
      BUSY: begin
        if (r_cnt >= DONE_CNT) begin
          if (i_ap_start) begin
            w_cntNext = ONE_CNT;
          end else begin
            w_stateNext = IDLE;
            w_cntNext   = '0;
            w_idleNext  = 1'b1;
          end
        end else begin
          w_cntNext = r_cnt + ONE_CNT;
          if ((r_cnt < READY_CNT) && !i_ap_start) begin
            w_startViol = 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_cntNext   = '0;
        w_idleNext  = 1'b1;
      end
    endcase
    w_readySet = (w_stateNext == BUSY) && (w_cntNext == READY_CNT);
    w_doneSet  = (w_stateNext == BUSY) && (w_cntNext == DONE_CNT);
  end

  assign w_busyNow = (r_state == BUSY);

  hls_sat_counter #(
    .CNT_W (CNT_W)
  ) u_doneCounter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_doneSet),
    .o_count (o_doneCount)
  );

  hls_sat_counter #(
    .CNT_W (CNT_W)
  ) u_busyCounter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_busyNow),
    .o_count (o_busyCycles)
  );

  assign o_ap_idle     = r_idle;
  assign o_ap_ready    = r_ready;
  assign o_ap_done     = r_done;
  assign o_protocolErr = r_protoErr;

endmodule
